// File: rtl/wc_pin_bridge.sv
// wc_pin_bridge: pad-reduction bridge in front of the Winograd core.
// The bridge gathers one input tile from narrow beats and drives it onto the
// core's wide D bus. It waits a fixed core latency, captures the core's Z bus,
// and then returns the result tile over narrow beats. Both narrow sides use a
// valid/ready handshake, and only one tile is in flight at a time.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   abort         synchronous: drop the current tile and return to LOAD
//   in_valid/in_ready/in_data      narrow input beats, lane j at [j*DW +: DW]
//   core_d        wide tile to the core, element i at [i*DW +: DW]
//   core_z        wide result from the core, element i at [i*DW +: DW]
//   out_valid/out_ready/out_data   narrow output beats, lane j at [j*DW +: DW]
//   out_last      marks the final output beat of a tile
//   tile_cnt      completed tiles, modulo 2^16
module wc_pin_bridge #(
    parameter int unsigned DW        = 10,
    parameter int unsigned IN_ELEMS  = 5,
    parameter int unsigned OUT_ELEMS = 2,
    parameter int unsigned LANES_IN  = 1,
    parameter int unsigned LANES_OUT = 1,
    parameter int unsigned CORE_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES_IN*DW-1:0]    in_data,
    output logic [IN_ELEMS*DW-1:0]    core_d,
    input  logic [OUT_ELEMS*DW-1:0]   core_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES_OUT*DW-1:0]   out_data,
    output logic                      out_last,
    output logic [15:0]               tile_cnt
);

    localparam int unsigned IN_BEATS  = IN_ELEMS / LANES_IN;
    localparam int unsigned OUT_BEATS = OUT_ELEMS / LANES_OUT;
    localparam int unsigned IW        = LANES_IN * DW;
    localparam int unsigned OW        = LANES_OUT * DW;
    localparam int unsigned BC_W      = $clog2(IN_BEATS) + 1;
    localparam int unsigned OB_W      = $clog2(OUT_BEATS) + 1;
    localparam int unsigned WT_W      = $clog2(CORE_LAT + 1) + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t                  state;
    logic [BC_W-1:0]         beat_cnt;
    logic [WT_W-1:0]         wait_cnt;
    logic [OB_W-1:0]         ob_cnt;
    logic [OUT_ELEMS*DW-1:0] z_reg;

    logic [OB_W-1:0]         ob_next;
    logic [OW-1:0]           next_beat;

    // Next output beat, selected from the captured result tile.
    always_comb begin
        ob_next   = ob_cnt + OB_W'(1);
        next_beat = '0;
        for (int unsigned i = 0; i < OUT_BEATS; i++) begin
            if (ob_next == OB_W'(i)) begin
                next_beat = z_reg[i*OW +: OW];
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            ob_cnt    <= '0;
            core_d    <= '0;
            z_reg     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            tile_cnt  <= '0;
        end else if (abort) begin
            // Abort drops the tile; the core_d and z_reg contents are kept.
            state     <= ST_LOAD;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            ob_cnt    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // Beats write directly into their core_d slot.
                        for (int unsigned i = 0; i < IN_BEATS; i++) begin
                            if (beat_cnt == BC_W'(i)) begin
                                core_d[i*IW +: IW] <= in_data;
                            end
                        end
                        if (beat_cnt == BC_W'(IN_BEATS - 1)) begin
                            beat_cnt <= '0;
                            wait_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= ST_WAIT;
                        end else begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    // Sample Z one edge after the core latency has elapsed.
                    if (wait_cnt == WT_W'(CORE_LAT)) begin
                        z_reg     <= core_z;
                        out_data  <= core_z[OW-1:0];
                        out_valid <= 1'b1;
                        out_last  <= (OUT_BEATS == 1);
                        ob_cnt    <= '0;
                        wait_cnt  <= '0;
                        state     <= ST_UNLOAD;
                    end else begin
                        wait_cnt <= wait_cnt + WT_W'(1);
                    end
                end

                ST_UNLOAD: begin
                    if (out_valid && out_ready) begin
                        if (ob_cnt == OB_W'(OUT_BEATS - 1)) begin
                            tile_cnt  <= tile_cnt + 16'd1;
                            ob_cnt    <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= ST_LOAD;
                        end else begin
                            ob_cnt   <= ob_next;
                            out_data <= next_beat;
                            out_last <= (ob_next == OB_W'(OUT_BEATS - 1));
                        end
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wc_pin_bridge.sv
// Directed bench for wc_pin_bridge with a two-stage behavioural core model:
// Z0 = d0+d1 and Z1 = d2+d3+d4, each truncated to 10 bits.
module tb_wc_pin_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic [49:0] core_d;
    logic [19:0] core_z;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        out_last;
    logic [15:0] tile_cnt;

    int tests = 0;
    int fails = 0;

    logic [19:0] zp1 = '0;
    logic [19:0] zp2 = '0;

    always #5 clk = ~clk;

    wc_pin_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_d    (core_d),
        .core_z    (core_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .tile_cnt  (tile_cnt)
    );

    // Core model, latency two edges.
    function automatic logic [19:0] core_fn(input logic [49:0] d);
        logic [9:0] z0;
        logic [9:0] z1;
        z0 = d[9:0] + d[19:10];
        z1 = d[29:20] + d[39:30] + d[49:40];
        return {z1, z0};
    endfunction

    always @(posedge clk) begin
        zp1 <= core_fn(core_d);
        zp2 <= zp1;
    end
    assign core_z = zp2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back load; starts and ends at 1 time unit after an edge.
    task automatic load_tile(input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2,
                             input logic [9:0] d3, input logic [9:0] d4);
        logic [9:0] v [5];
        v[0] = d0; v[1] = d1; v[2] = d2; v[3] = d3; v[4] = d4;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Exact WAIT length of three cycles, then two beats with out_ready=1.
    task automatic expect_tile(input string tag, input logic [9:0] z0, input logic [9:0] z1,
                               input logic [15:0] cnt);
        out_ready = 1'b1;
        chk({tag, "_wait0"}, out_valid, 1'b0);
        tick();
        chk({tag, "_wait1"}, out_valid, 1'b0);
        tick();
        chk({tag, "_wait2"}, out_valid, 1'b0);
        tick();
        chk({tag, "_v0"}, out_valid, 1'b1);
        chk({tag, "_d0"}, out_data, z0);
        chk({tag, "_l0"}, out_last, 1'b0);
        tick();
        chk({tag, "_v1"}, out_valid, 1'b1);
        chk({tag, "_d1"}, out_data, z1);
        chk({tag, "_l1"}, out_last, 1'b1);
        tick();
        chk({tag, "_vdone"}, out_valid, 1'b0);
        chk({tag, "_ldone"}, out_last, 1'b0);
        chk({tag, "_cnt"}, tile_cnt, cnt);
        chk({tag, "_rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 10'd99;
        out_ready = 1'b0;

        // 1: reset state with in_valid high
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_core_d", core_d, 50'd0);
        chk("rst_tile_cnt", tile_cnt, 16'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rel_in_ready", in_ready, 1'b1);

        // 2: back-to-back load of 1..5
        load_tile(10'd1, 10'd2, 10'd3, 10'd4, 10'd5);
        chk("load_e0", core_d[9:0], 10'd1);
        chk("load_e4", core_d[49:40], 10'd5);
        chk("load_in_ready", in_ready, 1'b0);

        // 3: wait and unload
        expect_tile("t3", 10'd3, 10'd12, 16'd1);

        // 4: back-pressure during UNLOAD
        out_ready = 1'b0;
        load_tile(10'd1, 10'd2, 10'd3, 10'd4, 10'd5);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("bp_valid_timeout", out_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_data_hold", out_data, 10'd3);
            chk("bp_last_hold", out_last, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_d1", out_data, 10'd12);
        chk("bp_l1", out_last, 1'b1);
        tick();
        chk("bp_done_valid", out_valid, 1'b0);
        chk("bp_cnt", tile_cnt, 16'd2);

        // 5: bubbles, abort after three beats, then a fresh tile 6..10
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 10'd99; tick();
        in_valid = 1'b0; in_data = 10'd0;  tick();
        chk("bub_hold", core_d[9:0], 10'd99);
        in_valid = 1'b1; in_data = 10'd98; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 10'd97; tick();
        abort = 1'b1; in_data = 10'd96; tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_cnt", tile_cnt, 16'd2);
        chk("abort_discard", core_d[39:30], 10'd4);
        chk("abort_keep", core_d[29:20], 10'd97);
        load_tile(10'd6, 10'd7, 10'd8, 10'd9, 10'd10);
        chk("fresh_e0", core_d[9:0], 10'd6);
        expect_tile("t5", 10'd13, 10'd27, 16'd3);

        // 6: reset during the second UNLOAD beat
        out_ready = 1'b0;
        load_tile(10'd1, 10'd2, 10'd3, 10'd4, 10'd5);
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("r6_valid_timeout", out_valid, 1'b1);
        tick();
        chk("r6_second_beat", out_last, 1'b1);
        rst = 1'b1;
        #1;
        chk("r6_async_valid", out_valid, 1'b0);
        chk("r6_async_last", out_last, 1'b0);
        chk("r6_cnt", tile_cnt, 16'd0);
        chk("r6_core_d", core_d, 50'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("r6_rel_ready", in_ready, 1'b1);
        load_tile(10'd1, 10'd2, 10'd3, 10'd4, 10'd5);
        expect_tile("t6", 10'd3, 10'd12, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
